// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the fetch queue.
// fetch_slot_t : one instruction slot as delivered by fetch (pc, BTB hit,
//                predicted-taken, predicted target, exception flag and code).
// fetch_pkt_t  : FETCH_WIDTH slots forming one queue entry.
package fetch_pkg;
  localparam int FETCH_WIDTH = 4;
  localparam int EXCP_CODE_W = 5;

  typedef struct packed {
    logic [31:0]            pc;
    logic                   hit;
    logic                   predict;
    logic [31:0]            target;
    logic                   has_excp;
    logic [EXCP_CODE_W-1:0] excp_code;
  } fetch_slot_t;

  typedef fetch_slot_t [FETCH_WIDTH-1:0] fetch_pkt_t;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// Bundle of all handshake/data signals between the fetch register, the
// fetch queue and decode.
//   slave  : the queue (takes in_* / out_ready / flush, drives out_* /
//            stall_ifr / count)
//   master : the environment (fetch register + decode)
interface inst_fetch_queue_if #(parameter int DEPTH = 4);
  import fetch_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                                     flush;
  logic                                     in_valid;
  logic [FETCH_WIDTH-1:0][31:0]             in_pc;
  logic [FETCH_WIDTH-1:0]                   in_hit;
  logic [FETCH_WIDTH-1:0]                   in_predict;
  logic [FETCH_WIDTH-1:0][31:0]             in_target;
  logic [FETCH_WIDTH-1:0]                   in_has_excp;
  logic [FETCH_WIDTH-1:0][EXCP_CODE_W-1:0]  in_excp_code;
  logic                                     stall_ifr;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [FETCH_WIDTH-1:0][31:0]             out_pc;
  logic [FETCH_WIDTH-1:0]                   out_hit;
  logic [FETCH_WIDTH-1:0]                   out_predict;
  logic [FETCH_WIDTH-1:0][31:0]             out_target;
  logic [FETCH_WIDTH-1:0]                   out_has_excp;
  logic [FETCH_WIDTH-1:0][EXCP_CODE_W-1:0]  out_excp_code;
  logic [CW-1:0]                            count;

  modport slave (
    input  flush, in_valid, in_pc, in_hit, in_predict, in_target,
           in_has_excp, in_excp_code, out_ready,
    output stall_ifr, out_valid, out_pc, out_hit, out_predict, out_target,
           out_has_excp, out_excp_code, count
  );

  modport master (
    output flush, in_valid, in_pc, in_hit, in_predict, in_target,
           in_has_excp, in_excp_code, out_ready,
    input  stall_ifr, out_valid, out_pc, out_hit, out_predict, out_target,
           out_has_excp, out_excp_code, count
  );
endinterface

// File: rtl/inst_fetch_queue_ptr_ctrl.sv
// Pointer/occupancy control for the fetch queue.
// Owns head, tail and count; qualifies push/pop and applies flush.
//   clk, rst           : clock, async active-high reset
//   flush              : empties the queue next cycle (wins over push/pop)
//   in_valid/out_ready : raw requests from fetch register / decode
//   push/pop           : qualified write/read strobes for the storage
//   stall_ifr          : full, back-pressure to fetch register
//   out_valid          : queue non-empty
//   head/tail/count    : registered pointers and occupancy
module fq_ptr_ctrl #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          push,
  output logic          pop,
  output logic          stall_ifr,
  output logic          out_valid,
  output logic [PW-1:0] head,
  output logic [PW-1:0] tail,
  output logic [CW-1:0] count
);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Both flags come from registered count only, so decode's out_ready has
  // no combinational path to stall_ifr.
  assign stall_ifr = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid  & ~stall_ifr & ~flush;
  assign pop       = out_valid & out_ready  & ~flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers are exactly PW bits, so +1 wraps mod DEPTH for free.
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch queue: consumer end of the fetch/decode pipeline register.
// Buffers up to DEPTH 4-wide fetch packets in a circular array and presents
// the oldest to decode with valid/ready. No bypass in either direction:
// a pushed packet is visible one cycle later, and a pop at full frees a
// slot only for the following cycle.
//   clk, rst : clock, async active-high reset (also clears storage)
//   q        : inst_fetch_queue_if slave port (in_*, out_*, flush,
//              stall_ifr, out_ready, count)
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SLOTS = FETCH_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic          push, pop;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .flush     (q.flush),
    .in_valid  (q.in_valid),
    .out_ready (q.out_ready),
    .push      (push),
    .pop       (pop),
    .stall_ifr (q.stall_ifr),
    .out_valid (q.out_valid),
    .head      (head),
    .tail      (tail),
    .count     (count)
  );

  assign q.count = count;

  fetch_pkt_t in_pkt, head_pkt;
  fetch_pkt_t mem_q [DEPTH];
  fetch_pkt_t mem_d [DEPTH];

  always_comb begin
    in_pkt = '0;
    for (int s = 0; s < SLOTS; s++) begin
      in_pkt[s].pc        = q.in_pc[s];
      in_pkt[s].hit       = q.in_hit[s];
      in_pkt[s].predict   = q.in_predict[s];
      in_pkt[s].target    = q.in_target[s];
      in_pkt[s].has_excp  = q.in_has_excp[s];
      in_pkt[s].excp_code = q.in_excp_code[s];
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[tail] = in_pkt;
  end

  // Storage is cleared on reset so out_* read zero, but flush leaves the
  // stale contents in place (only the pointers move).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head_pkt = mem_q[head];

  always_comb begin
    q.out_pc        = '0;
    q.out_hit       = '0;
    q.out_predict   = '0;
    q.out_target    = '0;
    q.out_has_excp  = '0;
    q.out_excp_code = '0;
    for (int s = 0; s < SLOTS; s++) begin
      q.out_pc[s]        = head_pkt[s].pc;
      q.out_hit[s]       = head_pkt[s].hit;
      q.out_predict[s]   = head_pkt[s].predict;
      q.out_target[s]    = head_pkt[s].target;
      q.out_has_excp[s]  = head_pkt[s].has_excp;
      q.out_excp_code[s] = head_pkt[s].excp_code;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
  import fetch_pkg::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.DEPTH(DEPTH)) bus();
  inst_fetch_queue #(.DEPTH(DEPTH), .SLOTS(FETCH_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  fetch_pkt_t mq[$];

  typedef struct {
    logic        iv, ordy, fl;
    logic [31:0] base;
    int          cnt;
    logic        vld, stl;
    logic [31:0] head;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic fetch_pkt_t gen_pkt(input logic [31:0] base);
    fetch_pkt_t p;
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      p[s].pc        = base + 32'(4 * s);
      p[s].hit       = (s == 1);
      p[s].predict   = (s == 2);
      p[s].target    = base + 32'h100 + 32'(4 * s);
      p[s].has_excp  = 1'b0;
      p[s].excp_code = 5'(s);
    end
    return p;
  endfunction

  function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                              input logic [31:0] base, input int cnt,
                              input logic vld, input logic stl, input logic [31:0] head);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.base = base;
    v.cnt = cnt; v.vld = vld; v.stl = stl; v.head = head;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic ordy, input logic fl, input fetch_pkt_t p);
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.flush     = fl;
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      bus.in_pc[s]        = p[s].pc;
      bus.in_hit[s]       = p[s].hit;
      bus.in_predict[s]   = p[s].predict;
      bus.in_target[s]    = p[s].target;
      bus.in_has_excp[s]  = p[s].has_excp;
      bus.in_excp_code[s] = p[s].excp_code;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string nm, input int cnt, input logic vld, input logic stl);
    chk({nm, ".count"}, 32'(bus.count), 32'(cnt));
    chk({nm, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
    chk({nm, ".stall_ifr"}, 32'(bus.stall_ifr), 32'(stl));
  endtask

  task automatic check_pkt(input string nm, input fetch_pkt_t e);
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      chk($sformatf("%s.pc[%0d]", nm, s), bus.out_pc[s], e[s].pc);
      chk($sformatf("%s.hit[%0d]", nm, s), 32'(bus.out_hit[s]), 32'(e[s].hit));
      chk($sformatf("%s.predict[%0d]", nm, s), 32'(bus.out_predict[s]), 32'(e[s].predict));
      chk($sformatf("%s.target[%0d]", nm, s), bus.out_target[s], e[s].target);
      chk($sformatf("%s.has_excp[%0d]", nm, s), 32'(bus.out_has_excp[s]), 32'(e[s].has_excp));
      chk($sformatf("%s.excp_code[%0d]", nm, s), 32'(bus.out_excp_code[s]), 32'(e[s].excp_code));
    end
  endtask

  localparam logic [31:0] B = 32'h1c00_0000;
  localparam logic [31:0] C = 32'h1c00_1000;

  initial begin
    fetch_pkt_t e;
    drive(1'b0, 1'b0, 1'b0, '0);

    // Reset held 3 cycles, then idle.
    repeat (3) tick;
    check_state("in_reset", 0, 1'b0, 1'b0);
    rst = 1'b0;
    check_state("post_reset", 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("idle%0d.count", i), 32'(bus.count), 32'd0);
    end

    // Single packet, then pop it.
    drive(1'b1, 1'b0, 1'b0, gen_pkt(B));
    tick;
    drive(1'b0, 1'b0, 1'b0, '0);
    check_state("single", 1, 1'b1, 1'b0);
    check_pkt("single", gen_pkt(B));
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    check_state("single_pop", 0, 1'b0, 1'b0);

    // Fill/stall, pop order, push+pop across the tail wrap, flush.
    tbl[0]  = mk(1, 0, 0, B + 32'h00, 1, 1, 0, B + 32'h00);
    tbl[1]  = mk(1, 0, 0, B + 32'h10, 2, 1, 0, B + 32'h00);
    tbl[2]  = mk(1, 0, 0, B + 32'h20, 3, 1, 0, B + 32'h00);
    tbl[3]  = mk(1, 0, 0, B + 32'h30, 4, 1, 1, B + 32'h00);
    tbl[4]  = mk(1, 0, 0, B + 32'h40, 4, 1, 1, B + 32'h00);
    tbl[5]  = mk(1, 1, 0, B + 32'h40, 3, 1, 0, B + 32'h10);
    tbl[6]  = mk(1, 0, 0, B + 32'h40, 4, 1, 1, B + 32'h10);
    tbl[7]  = mk(0, 1, 0, 32'h0,      3, 1, 0, B + 32'h20);
    tbl[8]  = mk(0, 1, 0, 32'h0,      2, 1, 0, B + 32'h30);
    tbl[9]  = mk(0, 1, 0, 32'h0,      1, 1, 0, B + 32'h40);
    tbl[10] = mk(0, 1, 0, 32'h0,      0, 0, 0, 32'h0);
    tbl[11] = mk(1, 0, 0, C + 32'h00, 1, 1, 0, C + 32'h00);
    tbl[12] = mk(1, 0, 0, C + 32'h10, 2, 1, 0, C + 32'h00);
    tbl[13] = mk(1, 1, 0, C + 32'h20, 2, 1, 0, C + 32'h10);
    tbl[14] = mk(1, 1, 0, C + 32'h30, 2, 1, 0, C + 32'h20);
    tbl[15] = mk(0, 1, 0, 32'h0,      1, 1, 0, C + 32'h30);
    tbl[16] = mk(1, 0, 0, C + 32'h40, 2, 1, 0, C + 32'h30);
    tbl[17] = mk(1, 0, 0, C + 32'h50, 3, 1, 0, C + 32'h30);
    tbl[18] = mk(1, 1, 1, C + 32'h60, 0, 0, 0, 32'h0);
    tbl[19] = mk(0, 0, 0, 32'h0,      0, 0, 0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, gen_pkt(tbl[i].base));
      tick;
      check_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].vld, tbl[i].stl);
      if (tbl[i].vld) check_pkt($sformatf("vec%0d", i), gen_pkt(tbl[i].head));
    end

    // Exception fields pass through untouched.
    e = gen_pkt(32'h1c00_0200);
    e[1].has_excp  = 1'b1;
    e[1].excp_code = 5'h08;
    e[2].hit       = 1'b1;
    e[2].predict   = 1'b1;
    e[2].target    = 32'h1c00_0100;
    drive(1'b1, 1'b0, 1'b0, e);
    tick;
    check_pkt("excp", e);
    chk("excp.has_excp_vec", 32'(bus.out_has_excp), 32'h2);
    chk("excp.code1", 32'(bus.out_excp_code[1]), 32'h08);
    chk("excp.target2", bus.out_target[2], 32'h1c00_0100);
    drive(1'b1, 1'b0, 1'b0, gen_pkt(32'h1c00_0300));
    tick;
    check_state("excp2", 2, 1'b1, 1'b0);

    // Async reset mid-cycle with the queue occupied.
    #2 rst = 1'b1;
    #1;
    check_state("async_rst", 0, 1'b0, 1'b0);
    check_pkt("async_rst", '0);
    tick;
    tick;
    check_state("rst_hold", 0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    tick;
    check_state("rst_rel", 0, 1'b0, 1'b0);

    // Randomized traffic against a queue model.
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      logic iv, ordy, fl;
      bit push_m, pop_m;
      fetch_pkt_t p;
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ((c / 400) % 2 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 39) == 0);
      for (int s = 0; s < FETCH_WIDTH; s++) begin
        p[s].pc        = $urandom;
        p[s].hit       = 1'($urandom_range(0, 1));
        p[s].predict   = 1'($urandom_range(0, 1));
        p[s].target    = $urandom;
        p[s].has_excp  = 1'($urandom_range(0, 1));
        p[s].excp_code = 5'($urandom_range(0, 31));
      end
      drive(iv, ordy, fl, p);
      push_m = iv && !fl && (mq.size() < DEPTH);
      pop_m  = ordy && !fl && (mq.size() > 0);
      tick;
      if (fl) mq.delete();
      else begin
        if (pop_m)  void'(mq.pop_front());
        if (push_m) mq.push_back(p);
      end
      check_state($sformatf("rnd%0d", c), mq.size(), mq.size() != 0, mq.size() == DEPTH);
      if (mq.size() > 0) check_pkt($sformatf("rnd%0d", c), mq[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
